// File: rtl/aes_ctr_dma_ctrl.sv
// -----------------------------------------------------------------------------
// aes_ctr_dma_ctrl
//
// Sequencer for the AES-CTR accelerator. Holds the MMIO configuration
// (base address, length, key, counter). On a start command it walks the
// buffer in 16-byte blocks:
//    READ    - fetch 16 bytes from XRAM into the block buffer
//    OPERATE - pulse aes_start, wait for the keystream, XOR it into the buffer
//    WRITE   - store the 16 bytes back in place, bump pointer and counter
//
// Ports
//    clk, rst            clock, asynchronous active-low reset
//    addr/data_in/stb/wr MMIO request (one request per two cycles at most)
//    ack/data_out        MMIO response, one cycle after stb
//    xram_*              byte-wide XRAM port, stb/addr/wr/data held until ack
//    aes_start           one-cycle request to the AES core
//    aes_key/aes_ctr     key and counter presented to the core
//    aes_done/aes_out    keystream result from the core
//
// MMIO map (byte i of key/counter lives at bits [127-8i -: 8])
//    0xff00       w: 0x01 = start      r: {6'b0, state}
//    0xff02/03    base address lo/hi
//    0xff04/05    length lo/hi (bytes)
//    0xff10-1f    key bytes 0..15
//    0xff20-2f    counter bytes 0..15
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module aes_ctr_dma_ctrl #(
   parameter int BLK_BYTES = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [15:0]  addr,
   input  logic [7:0]   data_in,
   input  logic         stb,
   input  logic         wr,
   output logic         ack,
   output logic [7:0]   data_out,
   output logic [15:0]  xram_addr,
   output logic [7:0]   xram_data_out,
   output logic         xram_stb,
   output logic         xram_wr,
   input  logic         xram_ack,
   input  logic [7:0]   xram_data_in,
   output logic         aes_start,
   output logic [127:0] aes_key,
   output logic [127:0] aes_ctr,
   input  logic         aes_done,
   input  logic [127:0] aes_out
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      OPERATE = 2'd2,
      WRITE   = 2'd3
   } state_t;

   localparam logic [3:0]  LAST_IDX = 4'(BLK_BYTES - 1);
   localparam logic [15:0] PTR_STEP = 16'(BLK_BYTES);

   state_t         state_reg, state_next;

   logic           ack_reg;
   logic [7:0]     data_out_reg;
   logic [15:0]    base_addr_reg;
   logic [15:0]    len_reg;
   logic [127:0]   key_reg;
   logic [127:0]   ctr_reg;
   logic [127:0]   buf_reg;
   logic [15:0]    ptr_reg;
   logic [12:0]    blk_cnt_reg;
   logic [3:0]     idx_reg;
   logic           op_first_reg;

   logic           mmio_req;
   logic           cfg_wr;
   logic           start_cmd;
   logic           rd_last;
   logic           wr_last;
   logic [7:0]     rd_data;
   logic [16:0]    len_round;

   logic [7:0]     key_bytes [16];
   logic [7:0]     ctr_bytes [16];
   logic [7:0]     buf_bytes [16];

   // Byte views of the 128-bit registers, byte 0 in the top bits.
   for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      assign key_bytes[gi] = key_reg[127-8*gi -: 8];
      assign ctr_bytes[gi] = ctr_reg[127-8*gi -: 8];
      assign buf_bytes[gi] = buf_reg[127-8*gi -: 8];
   end

   // A request is only taken outside the ack cycle, so back-to-back strobes
   // are served every other cycle.
   assign mmio_req  = stb && !ack_reg;
   assign cfg_wr    = mmio_req && wr && (state_reg == IDLE) && (addr[15:8] == 8'hff);
   assign start_cmd = cfg_wr && (addr[7:0] == 8'h00) && (data_in == 8'h01) &&
                      (len_reg != 16'h0000);
   assign rd_last   = (state_reg == READ)  && xram_ack && (idx_reg == LAST_IDX);
   assign wr_last   = (state_reg == WRITE) && xram_ack && (idx_reg == LAST_IDX);

   // ceil(length / 16) without losing the carry out of 0xffff + 15.
   assign len_round = {1'b0, len_reg} + 17'd15;

   assign ack      = ack_reg;
   assign data_out = data_out_reg;
   assign aes_key  = key_reg;
   assign aes_ctr  = ctr_reg;

   // -------------------------------------------------------------------------
   // MMIO read mux
   // -------------------------------------------------------------------------
   always_comb begin
      rd_data = 8'h00;
      if (addr[15:8] == 8'hff) begin
         case (addr[7:0])
            8'h00:   rd_data = {6'b0, state_reg};
            8'h02:   rd_data = base_addr_reg[7:0];
            8'h03:   rd_data = base_addr_reg[15:8];
            8'h04:   rd_data = len_reg[7:0];
            8'h05:   rd_data = len_reg[15:8];
            default: begin
               if (addr[7:4] == 4'h1) begin
                  rd_data = key_bytes[addr[3:0]];
               end else if (addr[7:4] == 4'h2) begin
                  rd_data = ctr_bytes[addr[3:0]];
               end
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_cmd) state_next = READ;
         READ:    if (rd_last)   state_next = OPERATE;
         OPERATE: if (aes_done)  state_next = WRITE;
         WRITE: begin
            if (wr_last) begin
               state_next = (blk_cnt_reg == 13'd1) ? IDLE : READ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs. Decoded from registered state, so they drop together with
   // the asynchronous reset and stay put while a transfer waits for its ack.
   // -------------------------------------------------------------------------
   always_comb begin
      xram_stb      = 1'b0;
      xram_wr       = 1'b0;
      xram_addr     = 16'h0000;
      xram_data_out = 8'h00;
      aes_start     = 1'b0;
      case (state_reg)
         READ: begin
            xram_stb  = 1'b1;
            xram_addr = ptr_reg + {12'h000, idx_reg};
         end
         OPERATE: begin
            aes_start = op_first_reg;
         end
         WRITE: begin
            xram_stb      = 1'b1;
            xram_wr       = 1'b1;
            xram_addr     = ptr_reg + {12'h000, idx_reg};
            xram_data_out = buf_bytes[idx_reg];
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath and configuration registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_reg       <= 1'b0;
         data_out_reg  <= 8'h00;
         base_addr_reg <= 16'h0000;
         len_reg       <= 16'h0000;
         key_reg       <= '0;
         ctr_reg       <= '0;
         buf_reg       <= '0;
         ptr_reg       <= 16'h0000;
         blk_cnt_reg   <= 13'd0;
         idx_reg       <= 4'd0;
         op_first_reg  <= 1'b0;
      end else begin
         ack_reg      <= mmio_req;
         data_out_reg <= mmio_req ? rd_data : 8'h00;
         // Marks the first OPERATE cycle, which is the aes_start cycle.
         op_first_reg <= rd_last;

         // Configuration writes are only possible in IDLE, so they never
         // collide with the counter update in WRITE.
         if (cfg_wr) begin
            case (addr[7:0])
               8'h02: base_addr_reg[7:0]  <= data_in;
               8'h03: base_addr_reg[15:8] <= data_in;
               8'h04: len_reg[7:0]        <= data_in;
               8'h05: len_reg[15:8]       <= data_in;
               default: ;
            endcase
            for (int i = 0; i < 16; i++) begin
               if (addr[7:4] == 4'h1 && addr[3:0] == i[3:0]) begin
                  key_reg[127-8*i -: 8] <= data_in;
               end
               if (addr[7:4] == 4'h2 && addr[3:0] == i[3:0]) begin
                  ctr_reg[127-8*i -: 8] <= data_in;
               end
            end
         end

         if (start_cmd) begin
            ptr_reg     <= base_addr_reg;
            blk_cnt_reg <= len_round[16:4];
            idx_reg     <= 4'd0;
         end

         case (state_reg)
            READ: begin
               if (xram_ack) begin
                  for (int i = 0; i < 16; i++) begin
                     if (idx_reg == i[3:0]) begin
                        buf_reg[127-8*i -: 8] <= xram_data_in;
                     end
                  end
                  // Wraps back to 0 after the last byte, ready for WRITE.
                  idx_reg <= idx_reg + 4'd1;
               end
            end
            OPERATE: begin
               if (aes_done) begin
                  buf_reg <= buf_reg ^ aes_out;
               end
            end
            WRITE: begin
               if (xram_ack) begin
                  idx_reg <= idx_reg + 4'd1;
                  if (idx_reg == LAST_IDX) begin
                     ptr_reg     <= ptr_reg + PTR_STEP;
                     ctr_reg     <= ctr_reg + 128'd1;
                     blk_cnt_reg <= blk_cnt_reg - 13'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_ctr_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_ctr_dma_ctrl
//
// Directed bench for aes_ctr_dma_ctrl. XRAM model answers every request one
// cycle later; read data is the pattern 0xA0 + addr[7:0], writes land in a
// separate array for inspection. The AES core model returns ctr ^ key a
// programmable number of cycles after aes_start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes_ctr_dma_ctrl;

   localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CTR_RB = 128'h303132333435363738393a3b3c3d3e3f;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [15:0]  addr = 16'h0;
   logic [7:0]   data_in = 8'h0;
   logic         stb = 1'b0;
   logic         wr = 1'b0;
   logic         ack;
   logic [7:0]   data_out;
   logic [15:0]  xram_addr;
   logic [7:0]   xram_data_out;
   logic         xram_stb;
   logic         xram_wr;
   logic         xram_ack = 1'b0;
   logic [7:0]   xram_data_in = 8'h0;
   logic         aes_start;
   logic [127:0] aes_key;
   logic [127:0] aes_ctr;
   logic         aes_done;
   logic [127:0] aes_out;

   // bench-side model state
   logic [7:0]   wmem [0:65535];
   logic         xram_hold = 1'b0;
   logic         spur_done = 1'b0;
   int           core_lat = 1;
   logic         done_q = 1'b0;
   logic         pend = 1'b0;
   int           cnt = 0;
   logic [127:0] ks_q = '0;
   int           rd_cnt = 0;
   int           wr_cnt = 0;
   int           start_cnt = 0;
   int           stb_cycles = 0;

   int           n_checks = 0;
   int           n_errors = 0;

   always #5 clk = ~clk;

   aes_ctr_dma_ctrl #(.BLK_BYTES(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .data_in       (data_in),
      .stb           (stb),
      .wr            (wr),
      .ack           (ack),
      .data_out      (data_out),
      .xram_addr     (xram_addr),
      .xram_data_out (xram_data_out),
      .xram_stb      (xram_stb),
      .xram_wr       (xram_wr),
      .xram_ack      (xram_ack),
      .xram_data_in  (xram_data_in),
      .aes_start     (aes_start),
      .aes_key       (aes_key),
      .aes_ctr       (aes_ctr),
      .aes_done      (aes_done),
      .aes_out       (aes_out)
   );

   // XRAM model: one-cycle ack pulse per request, blocked while xram_hold.
   always @(posedge clk) begin
      xram_ack <= 1'b0;
      if (xram_stb === 1'b1 && !xram_ack && !xram_hold) begin
         xram_ack     <= 1'b1;
         xram_data_in <= 8'ha0 + xram_addr[7:0];
         if (xram_wr === 1'b1) begin
            wmem[xram_addr] <= xram_data_out;
            wr_cnt <= wr_cnt + 1;
            $display("XRAM wr %h <= %h", xram_addr, xram_data_out);
         end else begin
            rd_cnt <= rd_cnt + 1;
         end
      end
      if (xram_stb === 1'b1) stb_cycles <= stb_cycles + 1;
   end

   // AES core model: keystream = ctr ^ key captured at aes_start.
   always @(posedge clk) begin
      done_q <= 1'b0;
      if (aes_start === 1'b1) begin
         pend      <= 1'b1;
         cnt       <= core_lat;
         ks_q      <= aes_ctr ^ aes_key;
         start_cnt <= start_cnt + 1;
      end else if (pend) begin
         if (cnt <= 1) begin
            done_q <= 1'b1;
            pend   <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end
   assign aes_done = done_q | spur_done;
   assign aes_out  = ks_q;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic mmio_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; data_in = d; wr = 1'b1; stb = 1'b1;
      @(negedge clk);
      stb = 1'b0; wr = 1'b0;
      check("wr_ack", 128'(ack), 128'd1);
      $display("MMIO wr %h <= %h", a, d);
   endtask

   task automatic mmio_read(input logic [15:0] a, output logic [7:0] d);
      @(negedge clk);
      addr = a; wr = 1'b0; stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      check("rd_ack", 128'(ack), 128'd1);
      d = data_out;
      $display("MMIO rd %h => %h", a, d);
   endtask

   task automatic write128(input logic [15:0] base, input logic [127:0] v);
      for (int i = 0; i < 16; i++) mmio_write(base + 16'(i), v[127-8*i -: 8]);
   endtask

   task automatic read128(input logic [15:0] base, output logic [127:0] v);
      logic [7:0] b;
      v = '0;
      for (int i = 0; i < 16; i++) begin
         mmio_read(base + 16'(i), b);
         v[127-8*i -: 8] = b;
      end
   endtask

   task automatic run_op(input logic [15:0] base, input logic [15:0] len);
      mmio_write(16'hff02, base[7:0]);
      mmio_write(16'hff03, base[15:8]);
      mmio_write(16'hff04, len[7:0]);
      mmio_write(16'hff05, len[15:8]);
      mmio_write(16'hff00, 8'h01);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Poll status until IDLE; returns the set of states observed.
   task automatic wait_idle(output logic [3:0] mask);
      logic [7:0] s;
      logic       done;
      mask = 4'b0000;
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         mmio_read(16'hff00, s);
         mask = mask | (4'b0001 << s[1:0]);
         if (s == 8'h00) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("idle_timeout", 128'(done), 128'd1);
   endtask

   function automatic logic [127:0] exp_block(input logic [15:0] base, input logic [127:0] ctr);
      logic [127:0] ks, r;
      logic [15:0]  a;
      ks = ctr ^ KEY;
      r  = '0;
      for (int i = 0; i < 16; i++) begin
         a = base + 16'(i);
         r[127-8*i -: 8] = (8'ha0 + a[7:0]) ^ ks[127-8*i -: 8];
      end
      return r;
   endfunction

   function automatic logic [127:0] got_block(input logic [15:0] base);
      logic [127:0] r;
      logic [15:0]  a;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         a = base + 16'(i);
         r[127-8*i -: 8] = wmem[a];
      end
      return r;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]   b;
      logic [127:0] v;
      logic [3:0]   mask;
      int           r0, w0, s0, c0;
      logic         seen;

      // ---- reset ----
      rst = 1'b0;
      wait_cycles(3);
      check("rst_stb", 128'(xram_stb), 128'd0);
      check("rst_start", 128'(aes_start), 128'd0);
      rst = 1'b1;
      mmio_read(16'hff00, b);
      check("rst_status", 128'(b), 128'd0);
      check("rst_key", aes_key, 128'd0);
      check("rst_ctr", aes_ctr, 128'd0);

      // ---- configuration readback ----
      write128(16'hff10, KEY);
      write128(16'hff20, CTR_RB);
      read128(16'hff10, v);
      check("key_rb", v, KEY);
      read128(16'hff20, v);
      check("ctr_rb", v, CTR_RB);
      check("aes_key", aes_key, KEY);
      mmio_read(16'h1234, b);
      check("unmapped_rd", 128'(b), 128'd0);

      // ---- single block at 0x1000, counter 0 ----
      write128(16'hff20, 128'd0);
      r0 = rd_cnt; w0 = wr_cnt; s0 = start_cnt;
      run_op(16'h1000, 16'd16);
      check("start_stb", 128'(xram_stb), 128'd1);
      check("start_addr", 128'(xram_addr), 128'h1000);
      wait_idle(mask);
      check("sb_reads", 128'(rd_cnt - r0), 128'd16);
      check("sb_writes", 128'(wr_cnt - w0), 128'd16);
      check("sb_starts", 128'(start_cnt - s0), 128'd1);
      // keystream byte i equals i, pattern byte is 0xA0+i: every byte is 0xA0
      check("sb_data", got_block(16'h1000), {16{8'ha0}});
      read128(16'hff20, v);
      check("sb_ctr", v, 128'd1);
      mmio_read(16'hff00, b);
      check("sb_status", 128'(b), 128'd0);

      // ---- multi-block, length 40 -> 3 blocks ----
      r0 = rd_cnt; w0 = wr_cnt; s0 = start_cnt;
      run_op(16'h1000, 16'd40);
      wait_idle(mask);
      check("mb_states", 128'(mask), 128'b1111);
      check("mb_reads", 128'(rd_cnt - r0), 128'd48);
      check("mb_writes", 128'(wr_cnt - w0), 128'd48);
      check("mb_starts", 128'(start_cnt - s0), 128'd3);
      check("mb_blk0", got_block(16'h1000), exp_block(16'h1000, 128'd1));
      check("mb_blk1", got_block(16'h1010), exp_block(16'h1010, 128'd2));
      check("mb_blk2", got_block(16'h1020), exp_block(16'h1020, 128'd3));
      check("mb_ctr", aes_ctr, 128'd4);

      // ---- counter wrap ----
      write128(16'hff20, {128{1'b1}});
      run_op(16'h2000, 16'd1);
      wait_idle(mask);
      check("cw_ctr", aes_ctr, 128'd0);
      check("cw_data", got_block(16'h2000), exp_block(16'h2000, {128{1'b1}}));

      // ---- address wrap from 0xfff8 ----
      w0 = wr_cnt;
      run_op(16'hfff8, 16'd16);
      wait_idle(mask);
      check("aw_writes", 128'(wr_cnt - w0), 128'd16);
      check("aw_data", got_block(16'hfff8), exp_block(16'hfff8, 128'd0));
      // byte 8 -> 0x0000: pattern 0xA0 ^ key byte 8 (0x08)
      check("aw_byte0", 128'(wmem[16'h0000]), 128'ha8);
      check("aw_ctr", aes_ctr, 128'd1);

      // ---- busy rules: second start in READ, key write in OPERATE ----
      core_lat = 20;
      w0 = wr_cnt; s0 = start_cnt;
      run_op(16'h3000, 16'd16);
      mmio_write(16'hff00, 8'h01);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (aes_start === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("start_timeout", 128'(seen), 128'd1);
      mmio_write(16'hff10, 8'hee);
      check("busy_key", aes_key, KEY);
      wait_idle(mask);
      core_lat = 1;
      check("busy_starts", 128'(start_cnt - s0), 128'd1);
      check("busy_writes", 128'(wr_cnt - w0), 128'd16);
      check("busy_data", got_block(16'h3000), exp_block(16'h3000, 128'd1));
      check("busy_ctr", aes_ctr, 128'd2);

      // ---- start with length 0 ----
      c0 = stb_cycles;
      mmio_write(16'hff04, 8'h00);
      mmio_write(16'hff05, 8'h00);
      mmio_write(16'hff00, 8'h01);
      wait_cycles(10);
      check("len0_stb", 128'(stb_cycles - c0), 128'd0);
      mmio_read(16'hff00, b);
      check("len0_status", 128'(b), 128'd0);

      // ---- spurious aes_done in IDLE ----
      c0 = stb_cycles;
      @(negedge clk);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      wait_cycles(5);
      mmio_read(16'hff00, b);
      check("spur_status", 128'(b), 128'd0);
      check("spur_stb", 128'(stb_cycles - c0), 128'd0);
      check("spur_ctr", aes_ctr, 128'd2);

      // ---- reset during the 5th write ack wait ----
      w0 = wr_cnt;
      run_op(16'h4000, 16'd32);
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (wr_cnt - w0 >= 4) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("wr4_timeout", 128'(seen), 128'd1);
      xram_hold = 1'b1;
      wait_cycles(3);
      check("pre_rst_wr", 128'(xram_wr), 128'd1);
      check("pre_rst_addr", 128'(xram_addr), 128'h4004);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_xstb", 128'(xram_stb), 128'd0);
      check("rst_xwr", 128'(xram_wr), 128'd0);
      check("rst_xaddr", 128'(xram_addr), 128'd0);
      check("rst_xdata", 128'(xram_data_out), 128'd0);
      check("rst_ack", 128'(ack), 128'd0);
      check("rst_dout", 128'(data_out), 128'd0);
      check("rst_key2", aes_key, 128'd0);
      check("rst_ctr2", aes_ctr, 128'd0);
      @(negedge clk);
      xram_hold = 1'b0;
      rst = 1'b1;
      wait_cycles(5);
      check("rst_no_wr", 128'(wr_cnt - w0), 128'd4);
      mmio_read(16'hff00, b);
      check("post_status", 128'(b), 128'd0);
      mmio_read(16'hff02, b);
      check("post_base", 128'(b), 128'd0);
      read128(16'hff10, v);
      check("post_key", v, 128'd0);
      read128(16'hff20, v);
      check("post_ctr", v, 128'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_ctr_dma_ctrl.md
# aes_ctr_dma_ctrl

Control and sequencing block for the AES accelerator. It owns the MMIO configuration registers: base address, length, key and counter. On a start command it streams 16-byte blocks from XRAM and has the AES core encrypt the counter. It XORs the keystream into each block, writes the result back in place, and increments the counter. The block sits between the MMIO command bus and the AES round core plus XRAM port.

## Interface
Parameters:
- BLK_BYTES, 16, bytes per block; fixed at 16 (128-bit core).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  16  MMIO address.
- data_in  in  8  MMIO write data.
- stb  in  1  MMIO request strobe.
- wr  in  1  1 = write, 0 = read.
- ack  out  1  MMIO acknowledge, single-cycle pulse.
- data_out  out  8  MMIO read data; valid when ack = 1.
- xram_addr  out  16  XRAM byte address.
- xram_data_out  out  8  XRAM write data.
- xram_stb  out  1  XRAM request.
- xram_wr  out  1  XRAM write enable.
- xram_ack  in  1  XRAM transfer complete.
- xram_data_in  in  8  XRAM read data; valid with xram_ack.
- aes_start  out  1  one-cycle pulse: encrypt aes_ctr under aes_key.
- aes_key  out  128  key register.
- aes_ctr  out  128  counter register.
- aes_done  in  1  core result valid, pulse.
- aes_out  in  128  keystream block.

## Operation
MMIO register map. Byte i of key and counter maps to bits [127-8i -: 8].
- 0xff00 write with data 0x01 starts an operation. Any read of 0xff00 returns {6'b0, state}.
- 0xff02/0xff03: address, low/high byte.
- 0xff04/0xff05: length in bytes, low/high byte.
- 0xff10-0xff1f: key bytes 0-15.
- 0xff20-0xff2f: counter bytes 0-15.
- Unmapped addresses: ack with data_out = 0; writes have no effect.
- Register writes while state != IDLE are acked and dropped. Reads are always served.

States, 2-bit encoding:
- IDLE=0.
  - Start with length != 0: blk_cnt = ceil(length/16), ptr = address, go to READ.
  - Start with length 0: stay in IDLE.
- READ=1: issue 16 XRAM reads at ptr+i (i=0..15).
  - Byte i goes to buf[127-8i -: 8].
  - After the 16th ack, pulse aes_start and go to OPERATE.
- OPERATE=2: wait for aes_done, then latch buf ^= aes_out and go to WRITE.
- WRITE=3: issue 16 XRAM writes of buf bytes at ptr+i.
  - After the 16th ack: ptr += 16, counter += 1 (mod 2^128), blk_cnt -= 1.
  - If blk_cnt is now 0, go to IDLE; otherwise go to READ.
- The final partial block is processed in full: all 16 bytes are read and written back.
- ptr arithmetic is 16-bit and wraps from 0xffff to 0x0000.
- The counter update is visible on aes_ctr and at MMIO 0xff20-0xff2f.
- aes_done outside OPERATE is ignored.
- A start write while busy is ignored.

## Timing
- Reset (rst = 0, asynchronous) sets:
  - state IDLE and all registers to 0;
  - ack, data_out, xram_stb, xram_wr, xram_addr, xram_data_out and aes_start to 0.
- Reset mid-operation abandons the block with no further XRAM traffic. The counter is not updated.
- MMIO: stb sampled high in cycle N gives ack = 1 in cycle N+1 with data_out valid.
  - stb is ignored in the ack cycle: one request per two cycles at most.
  - A register write takes effect in cycle N+1.
  - A start accepted in cycle N gives state READ and xram_stb = 1 in cycle N+1.
- XRAM: xram_stb, xram_addr, xram_wr and xram_data_out hold stable until xram_ack is sampled high.
  - The next transfer's address is driven in the following cycle, with xram_stb still high.
  - xram_stb drops in the cycle after the last ack of a phase.
- aes_start pulses in the cycle after the 16th read ack, and aes_key and aes_ctr are stable from then until aes_done.
- Buffer XOR is captured on the aes_done edge. The first write request follows in the next cycle.
- Minimum latency per block with zero-wait XRAM and a one-cycle core: 16 + 2 + 16 + 1 cycles.

## Test plan
- Configuration readback: write key 0x00..0x0f to 0xff10-0xff1f and counter to 0xff20-0xff2f, then read all back.
  - Values match.
  - Each ack arrives exactly one cycle after stb.
- Single block: address 0x1000, length 16. XRAM model holds bytes 0xA0-0xAF; core model returns aes_out = ctr ^ key.
  - 16 reads at 0x1000-0x100f, one aes_start, then 16 writes of byte ^ keystream.
  - Counter reads back incremented by 1; status returns 0.
- Multi-block with partial length: length 40 gives 3 blocks covering addresses 0x1000-0x102f.
  - Counter ends at +3.
  - Status reads 1, 2, 3 during the respective phases.
- Wrap-around:
  - Counter 0xff..ff with a 1-block operation ends at 0.
  - Address 0xfff8 wraps ptr so bytes 8-15 go to 0x0000-0x0007.
- Busy and ignore rules:
  - A key write during OPERATE leaves aes_key unchanged.
  - A second start during READ gives no extra block.
  - Start with length 0 stays in IDLE with no xram_stb.
  - A spurious aes_done in IDLE has no effect.
- Reset mid-transfer: drop rst during the 5th WRITE ack wait.
  - xram_stb goes to 0 immediately and all outputs go to 0.
  - After release, state is IDLE and the registers read 0.
